elbeth_memory_arbiter: RTL and testbench

- Shares a single external memory port between the instruction-fetch requester and the data-memory requester.
- Sits between the IF/EXS memory interfaces and the memory bus.
- Generates the per-requester ready signals that the control unit uses for stall decisions (`stall = en & ~ready`).
- Latches one transaction at a time and carries a bus-timeout watchdog that reports a bus error to the granted requester.

---
 rtl/elbeth_memory_arbiter.sv | 107 ++++++++++
 tb/tb_elbeth_memory_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/elbeth_memory_arbiter.sv
// Shares one external memory port between the fetch and data requesters, with a bus-timeout watchdog.
// Optional round-robin arbitration is enabled by defining ELBETH_MEM_ARB_RR_EN.
module elbeth_memory_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_en,
    output logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  imem_ready,
    output logic                  imem_error,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic [3:0]            dmem_wr,
    input  logic                  dmem_en,
    output logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  dmem_ready,
    output logic                  dmem_error,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wr,
    output logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
    typedef enum logic {GRANT_IMEM, GRANT_DMEM} grant_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t           state;
    grant_t           last_grant;
    logic [CNT_W-1:0] timeout_cnt;
    logic             timeout_hit;
    logic             choose_dmem;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timeout_cnt == CNT_W'(TIMEOUT_CYCLES));

`ifdef ELBETH_MEM_ARB_RR_EN
    // With both pending, the requester that was not served last goes first.
    assign choose_dmem = dmem_en && (!imem_en || (last_grant == GRANT_IMEM));
`else
    // A stalled load/store freezes the whole pipeline, so data always wins.
    assign choose_dmem = dmem_en;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= GRANT_IMEM;
            timeout_cnt <= '0;
            mem_valid   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (choose_dmem) begin
                        mem_addr  <= dmem_addr;
                        mem_wdata <= dmem_wdata;
                        mem_wr    <= dmem_wr;
                        mem_valid <= 1'b1;
                        state     <= GNT_D;
                    end else if (imem_en) begin
                        mem_addr  <= imem_addr;
                        mem_wdata <= '0;
                        mem_wr    <= '0;
                        mem_valid <= 1'b1;
                        state     <= GNT_I;
                    end
                end
                GNT_I, GNT_D: begin
                    // Completion takes precedence over a watchdog expiry in the same cycle.
                    if (mem_ready) begin
                        mem_valid   <= 1'b0;
                        timeout_cnt <= '0;
                        last_grant  <= (state == GNT_D) ? GRANT_DMEM : GRANT_IMEM;
                        state       <= IDLE;
                    end else if (timeout_hit) begin
                        mem_valid   <= 1'b0;
                        timeout_cnt <= '0;
                        state       <= IDLE;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        timeout_cnt <= timeout_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    mem_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign imem_ready = mem_ready && imem_en && (state == GNT_I);
    assign dmem_ready = mem_ready && dmem_en && (state == GNT_D);
    assign imem_error = timeout_hit && !mem_ready && imem_en && (state == GNT_I);
    assign dmem_error = timeout_hit && !mem_ready && dmem_en && (state == GNT_D);
    assign imem_rdata = (state == GNT_I) ? mem_rdata : '0;
    assign dmem_rdata = (state == GNT_D) ? mem_rdata : '0;

endmodule

// File: tb/tb_elbeth_memory_arbiter.sv
// Directed bench for elbeth_memory_arbiter: a table of single transactions plus hand-written corner sequences.
module tb_elbeth_memory_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
`ifdef ELBETH_MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] imem_addr = '0;
    logic          imem_en = 1'b0;
    logic [DW-1:0] imem_rdata;
    logic          imem_ready;
    logic          imem_error;
    logic [AW-1:0] dmem_addr = '0;
    logic [DW-1:0] dmem_wdata = '0;
    logic [3:0]    dmem_wr = '0;
    logic          dmem_en = 1'b0;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ready;
    logic          dmem_error;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wr;
    logic          mem_valid;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    elbeth_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .imem_error(imem_error),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wr(dmem_wr), .dmem_en(dmem_en),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .dmem_error(dmem_error),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_d;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    wr;
        int            delay;
        logic [DW-1:0] rdata;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        logic [3:0]    exp_wr;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One complete transaction from IDLE; mem_ready is withheld for v.delay cycles after grant.
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        imem_en    = !v.is_d;
        dmem_en    = v.is_d;
        imem_addr  = v.addr;
        dmem_addr  = v.addr;
        dmem_wdata = v.wdata;
        dmem_wr    = v.wr;
        step();
        checkOutput({tag, "_valid"}, 64'(mem_valid), 64'(1));
        checkOutput({tag, "_addr"}, 64'(mem_addr), 64'(v.exp_addr));
        checkOutput({tag, "_wdata"}, 64'(mem_wdata), 64'(v.exp_wdata));
        checkOutput({tag, "_wr"}, 64'(mem_wr), 64'(v.exp_wr));
        for (int i = 0; i < v.delay; i++) begin
            checkOutput({tag, "_early_ready"}, 64'({imem_ready, dmem_ready}), 64'(0));
            step();
        end
        mem_ready = 1'b1;
        mem_rdata = v.rdata;
        #1;
        checkOutput({tag, "_ready"}, 64'({imem_ready, dmem_ready}), v.is_d ? 64'(1) : 64'(2));
        checkOutput({tag, "_rdata"}, 64'(v.is_d ? dmem_rdata : imem_rdata), 64'(v.rdata));
        checkOutput({tag, "_other_rdata"}, 64'(v.is_d ? imem_rdata : dmem_rdata), 64'(0));
        step();
        mem_ready = 1'b0;
        imem_en   = 1'b0;
        dmem_en   = 1'b0;
        #1;
        checkOutput({tag, "_idle_valid"}, 64'(mem_valid), 64'(0));
        checkOutput({tag, "_idle_ready"}, 64'({imem_ready, dmem_ready}), 64'(0));
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h100,  32'h5555_AAAA, 4'hF, 2, 32'hDEAD_BEEF, 32'h100,  32'h0,         4'h0};
        vecs[1] = '{1'b1, 32'h2004, 32'h0,         4'h0, 0, 32'h1234_5678, 32'h2004, 32'h0,         4'h0};
        vecs[2] = '{1'b1, 32'h2008, 32'hCAFE_F00D, 4'h3, 1, 32'h0BAD_0BAD, 32'h2008, 32'hCAFE_F00D, 4'h3};
        vecs[3] = '{1'b0, 32'h104,  32'h0,         4'h0, 3, 32'h0000_0013, 32'h104,  32'h0,         4'h0};
        vecs[4] = '{1'b1, 32'h3000, 32'h8765_4321, 4'hF, 0, 32'hFFFF_0000, 32'h3000, 32'h8765_4321, 4'hF};

        mem_rdata = 32'hA5A5_A5A5;
        rst = 1'b1;
        #12;
        checkOutput("rst_valid", 64'(mem_valid), 64'(0));
        checkOutput("rst_bus", {mem_addr, mem_wdata}, 64'(0));
        checkOutput("rst_wr", 64'(mem_wr), 64'(0));
        checkOutput("rst_rdy_err", 64'({imem_ready, dmem_ready, imem_error, dmem_error}), 64'(0));
        checkOutput("rst_rdata", {imem_rdata, dmem_rdata}, 64'(0));
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

        // Simultaneous requests; last grant was DMEM, so round-robin serves imem first.
        imem_en = 1'b1; imem_addr = 32'h300;
        dmem_en = 1'b1; dmem_addr = 32'h2000; dmem_wdata = 32'h1111_2222; dmem_wr = 4'hF;
        step();
        checkOutput("both_first_addr", 64'(mem_addr), RR ? 64'(32'h300) : 64'(32'h2000));
        checkOutput("both_first_wr", 64'(mem_wr), RR ? 64'(0) : 64'(4'hF));
        mem_ready = 1'b1;
        #1;
        checkOutput("both_first_ready", 64'({imem_ready, dmem_ready}), RR ? 64'(2) : 64'(1));
        step();
        mem_ready = 1'b0;
        if (RR) imem_en = 1'b0; else dmem_en = 1'b0;
        #1;
        checkOutput("both_gap_valid", 64'(mem_valid), 64'(0));
        step();
        checkOutput("both_second_valid", 64'(mem_valid), 64'(1));
        checkOutput("both_second_addr", 64'(mem_addr), RR ? 64'(32'h2000) : 64'(32'h300));
        mem_ready = 1'b1;
        #1;
        checkOutput("both_second_ready", 64'({imem_ready, dmem_ready}), RR ? 64'(1) : 64'(2));
        step();
        mem_ready = 1'b0; imem_en = 1'b0; dmem_en = 1'b0;
        step();

        // Watchdog expiry on a dmem read with no response.
        dmem_en = 1'b1; dmem_addr = 32'h40; dmem_wr = 4'h0;
        step();
        for (int i = 0; i < TO; i++) begin
            checkOutput($sformatf("to_wait%0d", i), 64'({mem_valid, dmem_error, imem_error}), 64'(4));
            step();
        end
        checkOutput("to_error", 64'({mem_valid, dmem_error, imem_error, dmem_ready}), 64'(4'b1100));
        step();
        checkOutput("to_after", 64'({mem_valid, dmem_error}), 64'(0));
        dmem_en = 1'b0;
        step();

        // Response arriving exactly at expiry counts as completion.
        dmem_en = 1'b1; dmem_addr = 32'h44;
        step();
        for (int i = 0; i < TO; i++) step();
        mem_ready = 1'b1; mem_rdata = 32'h7777_8888;
        #1;
        checkOutput("exp_ready", 64'({dmem_ready, dmem_error}), 64'(2));
        checkOutput("exp_rdata", 64'(dmem_rdata), 64'(32'h7777_8888));
        step();
        mem_ready = 1'b0; dmem_en = 1'b0;
        #1;
        checkOutput("exp_idle", 64'(mem_valid), 64'(0));
        step();

        // dmem drops its request mid-grant while imem is waiting.
        dmem_en = 1'b1; dmem_addr = 32'h50;
        step();
        dmem_en = 1'b0; imem_en = 1'b1; imem_addr = 32'h180;
        step();
        mem_ready = 1'b1;
        #1;
        checkOutput("drop_no_ready", 64'({imem_ready, dmem_ready}), 64'(0));
        step();
        mem_ready = 1'b0;
        #1;
        checkOutput("drop_idle", 64'(mem_valid), 64'(0));
        step();
        checkOutput("drop_next_grant", {31'b0, mem_valid, mem_addr}, {31'b0, 1'b1, 32'h180});
        mem_ready = 1'b1;
        #1;
        checkOutput("drop_next_ready", 64'(imem_ready), 64'(1));
        step();
        mem_ready = 1'b0; imem_en = 1'b0;
        step();

        // Asynchronous reset in the middle of an imem grant.
        imem_en = 1'b1; imem_addr = 32'h200;
        step();
        checkOutput("ar_granted", 64'(mem_valid), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_valid_low", 64'(mem_valid), 64'(0));
        mem_ready = 1'b1;
        #1;
        checkOutput("ar_no_ready", 64'(imem_ready), 64'(0));
        imem_en = 1'b0; mem_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
        checkOutput("ar_idle", 64'({mem_valid, imem_ready}), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
